// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/trap outputs between controller, datapath and PC sequencer
interface pc_sequencer_if #(
    parameter int NBITS = 8,
    parameter int NIRQ  = 4
);
    localparam int SW = $clog2(NIRQ) + 1;
    logic             busy;
    logic             Branch;
    logic             eflag;
    logic             ju;
    logic             jr;
    logic             sret;
    logic [NBITS-1:0] IMM;
    logic [NBITS-1:0] PCReg;
    logic [NIRQ-1:0]  irq;
    logic             irq_en;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] pc_next;
    logic [NBITS-1:0] pclink;
    logic             link;
    logic [NBITS-1:0] sepc;
    logic [SW-1:0]    scause;
    logic             in_trap;
    logic [NIRQ-1:0]  pending;
    modport master (
        output busy, Branch, eflag, ju, jr, sret, IMM, PCReg, irq, irq_en,
        input  pc, pc_next, pclink, link, sepc, scause, in_trap, pending
    );
    modport slave (
        input  busy, Branch, eflag, ju, jr, sret, IMM, PCReg, irq, irq_en,
        output pc, pc_next, pclink, link, sepc, scause, in_trap, pending
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC sequencer with boot cycle, stall hold, edge-latched interrupts and trap entry/return
// Define PC_SEQ_VECTORED_EN to send trap i to TRAP_VECTOR + 4*i instead of TRAP_VECTOR.
module pc_sequencer #(
    parameter int NBITS       = 8,
    parameter int NIRQ        = 4,
    parameter int RESET_PC    = 0,
    parameter int TRAP_VECTOR = 'hE0
) (
    input logic clock,
    input logic reset,
    pc_sequencer_if.slave bus
);
    localparam int SW = $clog2(NIRQ) + 1;
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
    state_t           state, state_n;
    logic [NBITS-1:0] pc, pc_next, pc4, ppc, sepc, vec;
    logic [NIRQ-1:0]  pending, irq_q, clr;
    logic [SW-1:0]    scause, idx;
    logic             take;
    assign pc4  = pc + NBITS'(4);
    assign take = (state == RUN) && bus.irq_en && (|pending) && !bus.busy;
    assign clr  = take ? (NIRQ'(1) << idx) : '0;
`ifdef PC_SEQ_VECTORED_EN
    assign vec = NBITS'(TRAP_VECTOR) + (NBITS'(idx) << 2);
`else
    assign vec = NBITS'(TRAP_VECTOR);
`endif
    // lowest-numbered pending request wins
    always_comb begin
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (pending[i]) idx = SW'(i);
    end
    // next PC ignoring traps: stall, return, register jump, relative jump, sequential
    always_comb begin
        ppc = bus.busy ? pc :
              (bus.sret && state == TRAP) ? sepc :
              bus.jr ? bus.PCReg :
              (bus.ju || (bus.Branch && bus.eflag)) ? pc + bus.IMM : pc4;
    end
    // next state and instruction memory address
    always_comb begin
        state_n = state;
        pc_next = ppc;
        if (state == BOOT) begin
            state_n = RUN;
            pc_next = NBITS'(RESET_PC);
        end else if (take) begin
            state_n = TRAP;
            pc_next = vec;
        end else if (state == TRAP && bus.sret && !bus.busy) begin
            state_n = RUN;
        end
    end
    // state, PC, trap context and interrupt latches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= BOOT;
            pc      <= NBITS'(RESET_PC);
            sepc    <= '0;
            scause  <= '0;
            pending <= '0;
            irq_q   <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_next;
            irq_q   <= bus.irq;
            pending <= (pending & ~clr) | (bus.irq & ~irq_q);
            if (take) begin
                sepc   <= ppc;
                scause <= idx;
            end
        end
    end
    assign bus.pc      = pc;
    assign bus.pc_next = pc_next;
    assign bus.pclink  = pc4;
    assign bus.link    = (state != BOOT) && (bus.ju || bus.jr) && !bus.busy && !take;
    assign bus.sepc    = sepc;
    assign bus.scause  = scause;
    assign bus.in_trap = (state == TRAP);
    assign bus.pending = pending;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with an expectation queue drained by a negedge monitor
module tb_pc_sequencer;
    logic clock = 0;
    logic reset = 0;
    pc_sequencer_if #(.NBITS(8), .NIRQ(4)) bus();
    pc_sequencer #(.NBITS(8), .NIRQ(4), .RESET_PC(0), .TRAP_VECTOR('hE0)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    typedef enum int {S_PC, S_NEXT, S_PCLINK, S_LINK, S_SEPC, S_CAUSE, S_TRAP, S_PEND} sig_t;
    typedef struct {
        sig_t  sig;
        int    val;
        string name;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    function automatic int actual(sig_t s);
        case (s)
            S_PC:     return int'(bus.pc);
            S_NEXT:   return int'(bus.pc_next);
            S_PCLINK: return int'(bus.pclink);
            S_LINK:   return int'(bus.link);
            S_SEPC:   return int'(bus.sepc);
            S_CAUSE:  return int'(bus.scause);
            S_TRAP:   return int'(bus.in_trap);
            default:  return int'(bus.pending);
        endcase
    endfunction
    function automatic int vec(int i);
`ifdef PC_SEQ_VECTORED_EN
        return ('hE0 + 4 * i) & 'hFF;
`else
        return 'hE0 + 0 * i;
`endif
    endfunction
    task automatic push(sig_t s, int v, string n);
        q.push_back('{s, v, n});
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    // monitor: compare every queued expectation against the DUT mid-cycle
    initial begin
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                exp_t e;
                int a;
                e = q.pop_front();
                a = actual(e.sig);
                checks++;
                if (a != e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
                end
            end
        end
    end
    initial begin
        bus.busy = 0; bus.Branch = 0; bus.eflag = 0; bus.ju = 0; bus.jr = 0; bus.sret = 0;
        bus.IMM = 0; bus.PCReg = 0; bus.irq = 0; bus.irq_en = 0;
        push(S_PC, 0, "rst_pc"); push(S_PCLINK, 4, "rst_pclink"); push(S_SEPC, 0, "rst_sepc");
        push(S_CAUSE, 0, "rst_scause"); push(S_PEND, 0, "rst_pending");
        push(S_TRAP, 0, "rst_in_trap"); push(S_LINK, 0, "rst_link");
        step(); reset = 1;
        push(S_PC, 0, "boot_pc"); push(S_NEXT, 0, "boot_next");
        step(); push(S_PC, 0, "run0_pc"); push(S_NEXT, 4, "run0_next");
        step(); push(S_PC, 4, "seq4");
        step(); push(S_PC, 8, "seq8");
        bus.jr = 1; bus.PCReg = 8'hFC; push(S_LINK, 1, "jr_link"); push(S_NEXT, 'hFC, "jr_next");
        step(); bus.jr = 0;
        push(S_PC, 'hFC, "pc_fc"); push(S_NEXT, 0, "wrap_next"); push(S_PCLINK, 0, "wrap_pclink");
        step(); push(S_PC, 0, "wrap_pc");
        bus.jr = 1; bus.PCReg = 8'h10;
        step(); bus.jr = 0;
        bus.busy = 1; bus.ju = 1; bus.IMM = 8'hF8;
        push(S_PC, 'h10, "busy1_pc"); push(S_LINK, 0, "busy1_link"); push(S_NEXT, 'h10, "busy1_next");
        step(); push(S_PC, 'h10, "busy2_pc"); push(S_LINK, 0, "busy2_link");
        step(); push(S_PC, 'h10, "busy3_pc");
        step(); bus.busy = 0;
        push(S_PC, 'h10, "unbusy_pc"); push(S_LINK, 1, "unbusy_link");
        push(S_PCLINK, 'h14, "unbusy_pclink"); push(S_NEXT, 'h08, "unbusy_next");
        step(); bus.ju = 0; push(S_PC, 'h08, "ju_pc");
        bus.jr = 1; bus.ju = 1; bus.PCReg = 8'h40; bus.IMM = 8'h08;
        push(S_NEXT, 'h40, "jrju_next"); push(S_LINK, 1, "jrju_link");
        step(); bus.jr = 0; bus.ju = 0; push(S_PC, 'h40, "jrju_pc");
        bus.jr = 1; bus.PCReg = 8'h1C;
        step(); bus.jr = 0;
        bus.irq_en = 1; bus.irq = 4'b0101;
        push(S_PC, 'h1C, "irq_edge_pc"); push(S_PEND, 0, "irq_edge_pend");
        step();
        push(S_PC, 'h20, "take_pc"); push(S_PEND, 5, "take_pend");
        push(S_NEXT, vec(0), "take_next"); push(S_LINK, 0, "take_link");
        step();
        push(S_PC, vec(0), "trap0_pc"); push(S_TRAP, 1, "trap0_in"); push(S_CAUSE, 0, "trap0_cause");
        push(S_SEPC, 'h24, "trap0_sepc"); push(S_PEND, 4, "trap0_pend");
        bus.sret = 1; push(S_NEXT, 'h24, "sret0_next");
        step(); bus.sret = 0;
        push(S_PC, 'h24, "ret0_pc"); push(S_TRAP, 0, "ret0_in"); push(S_NEXT, vec(2), "ret0_next");
        step();
        push(S_PC, vec(2), "trap2_pc"); push(S_CAUSE, 2, "trap2_cause");
        push(S_SEPC, 'h28, "trap2_sepc"); push(S_PEND, 0, "trap2_pend"); push(S_TRAP, 1, "trap2_in");
        bus.irq = 4'b0111;
        step(); push(S_PEND, 2, "intrap_latch"); push(S_TRAP, 1, "intrap_hold");
        bus.sret = 1;
        step(); bus.sret = 0;
        push(S_PC, 'h28, "ret2_pc"); push(S_NEXT, vec(1), "ret2_next");
        step();
        push(S_PC, vec(1), "trap1_pc"); push(S_CAUSE, 1, "trap1_cause");
        push(S_PEND, 0, "trap1_pend"); push(S_SEPC, 'h2C, "trap1_sepc");
        bus.sret = 1;
        step(); bus.sret = 0;
        push(S_PC, 'h2C, "ret1_pc"); push(S_PEND, 0, "held_pend0");
        push(S_TRAP, 0, "ret1_in"); push(S_NEXT, 'h30, "ret1_next");
        step(); push(S_PC, 'h30, "held_pc"); push(S_PEND, 0, "held_pend1");
        bus.irq = 4'b0101;
        step(); push(S_PEND, 0, "drop_pend");
        bus.irq = 4'b0111;
        step();
        push(S_PC, 'h38, "rerise_pc"); push(S_PEND, 2, "rerise_pend"); push(S_NEXT, vec(1), "rerise_next");
        step();
        push(S_PC, vec(1), "trap1b_pc"); push(S_PEND, 0, "trap1b_pend");
        push(S_SEPC, 'h3C, "trap1b_sepc"); push(S_TRAP, 1, "trap1b_in");
        bus.irq = 4'b1111;
        step(); push(S_PEND, 8, "pre_rst_pend"); push(S_TRAP, 1, "pre_rst_in");
        @(negedge clock);
        #1;
        bus.irq = 0; bus.irq_en = 0; reset = 0;
        #1;
        push(S_TRAP, 0, "async_in"); push(S_PEND, 0, "async_pend"); push(S_PC, 0, "async_pc");
        step(); reset = 1;
        push(S_PC, 0, "reboot_pc"); push(S_NEXT, 0, "reboot_next"); push(S_LINK, 0, "reboot_link");
        step(); push(S_PC, 0, "rerun_pc"); push(S_NEXT, 4, "rerun_next");
        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL queue_drain: got %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC-V processor's controller. It generalises the controller's PC path to NBITS-wide addresses and NIRQ interrupt lines. It adds sticky edge-latched interrupt requests, trap entry and return through `sepc`/`scause`, a boot cycle for the registered instruction memory, and busy-stall holding. It drives `pc_next` into the instruction memory and `pc`, `pclink` and `link` to the datapath.

## Interface
- `NBITS`, 8: address and data width.
- `NIRQ`, 4: interrupt request lines, 1..8.
- `RESET_PC`, 0: PC value at and after reset.
- `TRAP_VECTOR`, 'hE0: handler base address.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; all state is cleared while 0.
- `busy` input 1: memory or cache stall; hold the PC.
- `Branch` input 1: conditional branch instruction.
- `eflag` input 1: branch condition true.
- `ju` input 1: immediate unconditional jump.
- `jr` input 1: jump to register.
- `sret` input 1: return from handler.
- `IMM` input NBITS: signed branch/jump offset.
- `PCReg` input NBITS: register value, the jr target.
- `irq` input NIRQ: interrupt request levels.
- `irq_en` input 1: global interrupt enable.
- `pc` output NBITS: current instruction address.
- `pc_next` output NBITS: combinational next PC, the instruction memory address.
- `pclink` output NBITS: `pc+4`, the link value.
- `link` output 1: write `pclink` to RD.
- `sepc` output NBITS: return address.
- `scause` output $clog2(NIRQ)+1: cause index of the last trap taken.
- `in_trap` output 1: handler executing.
- `pending` output NIRQ: latched requests.

## Operation
- States:
  - BOOT: first cycle after reset release; `pc_next=RESET_PC`, no instruction is valid, go to RUN.
  - RUN: normal execution.
  - TRAP: handler executing; `in_trap=1`.
- Request latching:
  - Rising edge of `irq[i]` (0→1 versus the previous-cycle sample) sets `pending[i]`.
  - A level held high does not re-set it.
  - `pending[i]` is cleared only in the cycle its trap is taken.
  - An edge in the same cycle as a clear of the same bit leaves the bit set.
- `ppc` (next PC without trap), priority high→low:
  - `busy` → `pc`.
  - `sret` and TRAP → `sepc`.
  - `jr` → `PCReg`.
  - `ju` or (`Branch` & `eflag`) → `pc+IMM`.
  - otherwise → `pc+4`.
- Trap taken when all hold: state RUN, `irq_en=1`, `pending!=0`, `busy=0`.
  - Lowest pending index wins.
  - `sepc<=ppc`, `scause<=index`, `pending[index]<=0`, state→TRAP, `pc_next` = vector.
- TRAP ignores new traps; requests keep latching.
  - `sret` with `busy=0`: `pc_next=sepc`, state→RUN.
  - A pending trap can be taken the cycle after return.
- `sret` in RUN is ignored and treated as `pc+4`.
- `link=(ju|jr)&!busy&!trap_taken` outside BOOT.
- Arithmetic is modulo 2^NBITS; `pc+4` from 'hFC wraps to 0 at NBITS=8. `IMM` is used as NBITS two's complement.

## Timing
- `pc` register: `pc<=pc_next` every clock edge; `pc_next` is combinational from the current state and inputs.
- Instruction memory registers `pc_next`, so the instruction for `pc` is valid in the same cycle as `pc`.
- Reset values:
  - `pc=RESET_PC`, `sepc=0`, `scause=0`, `pending=0`, `in_trap=0`, `link=0`.
  - State=BOOT.
  - `pclink=RESET_PC+4`.
  - Previous `irq` sample = 0.
- Reset asserted mid-handler clears state immediately; in-flight trap and pending requests are lost.
- Trap latency: an `irq` edge at cycle n sets `pending` at edge n+1. The earliest vector fetch is `pc=vector` at edge n+2.

## Configuration
- `PC_SEQ_VECTORED_EN`:
  - Defined: vector = `TRAP_VECTOR + 4*index` (modulo 2^NBITS).
  - Undefined: every trap goes to `TRAP_VECTOR`; `scause` still records the index.

## Test plan
- Reset release with `RESET_PC=0`, no control inputs → `pc` sequence 0,0 (BOOT),4,8…; at 'hFC the next value is 0.
- `pc`='h10, `busy=1` for 3 cycles with `ju=1`, `IMM=-8` → `pc` holds 'h10 and `link=0`; first non-busy cycle gives `pc`='h08, `link=1`, `pclink`='h14.
- `jr=1` and `ju=1` together, `PCReg`='h40 → `pc`='h40 (jr priority).
- `irq[2]` and `irq[0]` rise together, `irq_en=1`, `pc`='h20 sequential:
  - Vectored build: `pc`='hE0 with `scause=0`, `sepc`='h24 (non-vectored gives `pc`='hE0 as well).
  - `pending`=4'b0100.
  - `sret` → `pc`='h24, then the next cycle traps with `scause=2`; vectored `pc`='hE8.
- `irq[1]` held high across a taken trap and `sret` → only one trap; `pending[1]` stays 0 until `irq[1]` drops and rises again.
- `reset` pulsed low for 1 cycle while in TRAP with `pending!=0` → `in_trap=0`, `pending=0`, `pc=RESET_PC` immediately (asynchronous), BOOT follows.
